// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH serial bits (MSB- or LSB-first per word)
// into a word presented through a one-entry valid/ready holding register with sticky overrun.
module sipo_deserializer #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pout_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q;
    logic             order_eff;
    logic             pvalid_q;
    logic             ovr_q;
    logic             word_done;
    logic             slot_free;

    // The first bit of a word shifts in using the live msb_first, since the latch loads on that same edge.
    always_comb begin
        order_eff = (cnt_q == '0) ? msb_first : order_q;
        sr_d      = order_eff ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
        word_done = sin_valid && (cnt_q == CNT_LAST);
        cnt_d     = word_done ? '0 : cnt_q + CNT_ONE;
        slot_free = !pvalid_q || pout_ready;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            order_q  <= 1'b0;
        end else if (sync_clr) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (sin_valid) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_d;
                if (cnt_q == '0) begin
                    order_q <= msb_first;
                end
            end
            // A completing word may refill the slot on the same edge it is consumed.
            if (word_done && slot_free) begin
                pout_q   <= sr_d;
                pvalid_q <= 1'b1;
            end else if (word_done) begin
                ovr_q <= 1'b1;
            end else if (pout_ready) begin
                pvalid_q <= 1'b0;
            end
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pvalid_q;
    assign bit_count  = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: fixed vector table, directed corner sequences,
// and randomized traffic checked against a queue-based word model.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         clear;
    logic         sin;
    logic         sin_valid;
    logic         msb_first;
    logic         sync_clr;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready;
    logic [2:0]   bit_count;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .clear      (clear),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .msb_first  (msb_first),
        .sync_clr   (sync_clr),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       sv;
        bit       s;
        bit       mf;
        bit       sc;
        bit       rdy;
        logic [7:0] exp_pout;
        bit       exp_valid;
        int       exp_cnt;
        bit       exp_ovr;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: bits of the word in progress, in arrival order.
    bit         mdl_bits[$];
    bit         mdl_order;
    logic [7:0] mdl_pout;
    bit         mdl_valid;
    bit         mdl_ovr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] p, input bit v, input int c, input bit o);
        chk({tag, " pout"}, 64'(pout), 64'(p));
        chk({tag, " pout_valid"}, 64'(pout_valid), 64'(v));
        chk({tag, " bit_count"}, 64'(bit_count), 64'(c));
        chk({tag, " overrun"}, 64'(overrun), 64'(o));
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled at the next falling edge.
    task automatic cyc(input bit sv, input bit s, input bit mf, input bit sc, input bit rdy);
        sin_valid  = sv;
        sin        = s;
        msb_first  = mf;
        sync_clr   = sc;
        pout_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        #2 clear = 1'b0;
        #2 clear = 1'b1;
    endtask

    task automatic feed_word(input logic [7:0] w, input bit msb, input bit rdy_mid, input bit rdy_last);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, msb ? w[7-i] : w[i], msb, 1'b0, (i == 7) ? rdy_last : rdy_mid);
    endtask

    function automatic void add(input bit sv, input bit s, input bit mf, input bit sc, input bit rdy,
                                input logic [7:0] p, input bit v, input int c, input bit o);
        vec_t e;
        e.sv = sv; e.s = s; e.mf = mf; e.sc = sc; e.rdy = rdy;
        e.exp_pout = p; e.exp_valid = v; e.exp_cnt = c; e.exp_ovr = o;
        vecs.push_back(e);
    endfunction

    // One word with pout_ready=1, then one idle cycle; msb_first flips at bit index sw.
    function automatic void add_word(input logic [7:0] pat, input int sw, input bit mf0,
                                     input logic [7:0] prev, input logic [7:0] fin, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            bit mf;
            mf = (i < sw) ? mf0 : !mf0;
            if (gaps) begin
                int n;
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) add(1'b0, 1'b1, !mf, 1'b0, 1'b1, prev, 1'b0, i, 1'b0);
            end
            add(1'b1, pat[7-i], mf, 1'b0, 1'b1, (i == 7) ? fin : prev, i == 7, (i + 1) % 8, 1'b0);
        end
        add(1'b0, 1'b0, mf0, 1'b0, 1'b1, fin, 1'b0, 0, 1'b0);
    endfunction

    task automatic model_reset();
        mdl_bits.delete();
        mdl_order = 1'b0;
        mdl_pout  = '0;
        mdl_valid = 1'b0;
        mdl_ovr   = 1'b0;
    endtask

    task automatic model_edge(input bit sv, input bit s, input bit mf, input bit sc, input bit rdy);
        bit          done;
        logic [63:0] w;
        done = 1'b0;
        w    = '0;
        if (sc) begin
            mdl_bits.delete();
            mdl_pout  = '0;
            mdl_valid = 1'b0;
            mdl_ovr   = 1'b0;
            return;
        end
        if (sv) begin
            if (mdl_bits.size() == 0) mdl_order = mf;
            mdl_bits.push_back(s);
            if (mdl_bits.size() == W) begin
                for (int i = 0; i < W; i++)
                    if (mdl_bits[i]) w += mdl_order ? (64'd1 << (W - 1 - i)) : (64'd1 << i);
                mdl_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!mdl_valid || rdy) begin
                mdl_pout  = w[7:0];
                mdl_valid = 1'b1;
            end else begin
                mdl_ovr = 1'b1;
            end
        end else if (mdl_valid && rdy) begin
            mdl_valid = 1'b0;
        end
    endtask

    initial begin
        clear = 1'b1; sin = 1'b0; sin_valid = 1'b0; msb_first = 1'b0; sync_clr = 1'b0; pout_ready = 1'b0;

        // Asynchronous reset with no clock edge.
        #1 clear = 1'b0;
        #1 check_all("reset", 8'h00, 1'b0, 0, 1'b0);
        @(negedge clk);
        clear = 1'b1;

        // Table: MSB-first, LSB-first, order toggled mid-word, and idle gaps.
        add_word(8'hD0, 8, 1'b1, 8'h00, 8'hD0, 1'b0);
        add_word(8'hD0, 8, 1'b0, 8'hD0, 8'h0B, 1'b0);
        add_word(8'hD0, 3, 1'b0, 8'h0B, 8'h0B, 1'b0);
        add_word(8'hD0, 8, 1'b1, 8'h0B, 8'hD0, 1'b1);
        add_word(8'hD0, 8, 1'b0, 8'hD0, 8'h0B, 1'b1);
        foreach (vecs[k]) begin
            cyc(vecs[k].sv, vecs[k].s, vecs[k].mf, vecs[k].sc, vecs[k].rdy);
            check_all($sformatf("vec%0d", k), vecs[k].exp_pout, vecs[k].exp_valid,
                      vecs[k].exp_cnt, vecs[k].exp_ovr);
        end

        // Stalled consumer: second word dropped, overrun sticks through consumption.
        pulse_clear();
        feed_word(8'h3C, 1'b1, 1'b0, 1'b0);
        check_all("stall first", 8'h3C, 1'b1, 0, 1'b0);
        feed_word(8'hC3, 1'b1, 1'b0, 1'b0);
        check_all("stall drop", 8'h3C, 1'b1, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_all("stall consume", 8'h3C, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("sync_clr ovr", 8'h00, 1'b0, 0, 1'b0);

        // Consume and reload on the same edge.
        feed_word(8'h3C, 1'b1, 1'b0, 1'b0);
        check_all("hold 3C", 8'h3C, 1'b1, 0, 1'b0);
        feed_word(8'h5A, 1'b1, 1'b0, 1'b1);
        check_all("reload 5A", 8'h5A, 1'b1, 0, 1'b0);

        // Async clear mid-word with a pending word and overrun set.
        feed_word(8'h11, 1'b1, 1'b0, 1'b0);
        check_all("pre-clear", 8'h5A, 1'b1, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("3 bits", 8'h5A, 1'b1, 3, 1'b1);
        #2 clear = 1'b0;
        #1 check_all("async clear", 8'h00, 1'b0, 0, 1'b0);
        #1 clear = 1'b1;
        feed_word(8'hA5, 1'b1, 1'b0, 1'b0);
        check_all("after clear A5", 8'hA5, 1'b1, 0, 1'b0);

        // sync_clr beats the completing 8th bit.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("7 bits", 8'hA5, 1'b1, 7, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all("sync_clr last bit", 8'h00, 1'b0, 0, 1'b0);

        // Randomized traffic against the model.
        pulse_clear();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit sv, s, mf, sc, rdy;
            sv  = ($urandom_range(0, 9) < 7);
            s   = $urandom_range(0, 1) != 0;
            mf  = $urandom_range(0, 1) != 0;
            sc  = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            cyc(sv, s, mf, sc, rdy);
            model_edge(sv, s, mf, sc, rdy);
            check_all($sformatf("rnd%0d", n), mdl_pout, mdl_valid, mdl_bits.size(), mdl_ovr);
            if ($urandom_range(0, 399) == 0) begin
                pulse_clear();
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Parametrised serial-in/parallel-out deserializer. It is the next generation of the single-bit SIPO register chain.
- It accumulates WIDTH serial bits into a word, selecting MSB-first or LSB-first per word.
- Each completed word is presented on a parallel output held by a one-entry valid/ready holding register.
- It sits between a serial link receiver and word-wide downstream logic, and reports an overrun when that logic stalls.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the bit counter; local, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  active-low reset, asynchronous assert, synchronous deassert handled upstream.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this rising edge.
- msb_first  input  1  bit order for the word; 1 = first bit lands in pout[WIDTH-1].
- sync_clr  input  1  synchronous active-high flush.
- pout  output  WIDTH  assembled word.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout this cycle.
- bit_count  output  CNT_W  bits collected in the current word.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: clear=0 forces the following immediately, with no clock edge needed: shift reg=0, bit_count=0, pout=0, pout_valid=0, overrun=0, order latch=0.
- Order latch: msb_first is captured on the edge that samples the first bit (bit_count==0 && sin_valid). It applies to all WIDTH bits of that word. Changes to msb_first mid-word are ignored.
- Shift on sin_valid, MSB-first: sr <= {sr[WIDTH-2:0], sin}.
- Shift on sin_valid, LSB-first: sr <= {sin, sr[WIDTH-1:1]}.
- Bit count: bit_count increments on each sin_valid. It wraps to 0 on the edge sampling the WIDTH-th bit.
- Idle cycles: when sin_valid=0, sr and bit_count hold. Gaps of any length between bits are legal.
- Word complete: the edge where bit_count==WIDTH-1 && sin_valid.
  - The word is the post-shift value, including the current bit.
- Free slot: the holding register is free if pout_valid==0 or pout_ready==1 in the same cycle.
- On word complete with a free slot: pout <= word and pout_valid <= 1 on that edge.
  - Latency: pout_valid is high in the cycle after the last bit is sampled.
- On word complete with the slot not free: the word is discarded and overrun <= 1.
  - pout and pout_valid are unchanged.
  - bit_count still wraps to 0.
- Handshake:
  - pout_valid=1 && pout_ready=1 consumes the word.
  - pout_valid falls on that edge unless a new word completes on the same edge.
  - If a new word completes on the same edge, pout is reloaded, pout_valid stays 1 and there is no overrun.
  - While pout_valid=1 && pout_ready=0, pout is stable.
  - pout_ready is ignored when pout_valid=0.
- overrun: sticky; cleared only by clear or sync_clr.
- sync_clr=1 clears sr, bit_count, pout, pout_valid and overrun on the edge.
  - It has priority over sin_valid and pout_ready on the same edge; that bit is lost.
- Reset mid-word or with a pending word: everything is lost. There is no partial-word output.
- pout updates only on load. Between words it retains the last loaded value, except after a clear.

Test Plan:
1. WIDTH=8, pout_ready=1, msb_first=1, bits 1,1,0,1,0,0,0,0 on consecutive cycles -> pout=8'hD0 and pout_valid=1 for exactly one cycle, starting the cycle after the 8th bit; bit_count returns to 0.
2. Same bits with msb_first=0 -> pout=8'h0B. A repeat with msb_first toggled after bit 3 still yields 8'h0B. Random idle gaps between bits do not change the result.
3. pout_ready=0; word 8'h3C completes, then word 8'hC3 completes -> pout stays 8'h3C, pout_valid=1, overrun=1. Raise pout_ready for one cycle -> pout_valid=0 next cycle and overrun stays 1.
4. Hold pout_valid=1 with 8'h3C; pout_ready=1 on the same edge that word 8'h5A completes -> pout=8'h5A, pout_valid stays 1, overrun=0.
5. Feed 3 bits, then drive clear=0 between clock edges -> bit_count=0, pout_valid=0, overrun=0 with no clock edge. After release, a full 8-bit 8'hA5 MSB-first decodes correctly.
6. bit_count=7 with sin_valid=1 and sync_clr=1 on the same edge -> no word loaded, bit_count=0, pout_valid=0, overrun=0.
